// File: rtl/hv_bundler_unit.sv
// Element-wise majority bundler: one signed counter per hypervector bit, binarized on drain.
// Optional macro HV_BUNDLER_SATURATE_EN: counters clamp instead of wrapping.
module hv_bundler_unit #(
    parameter int unsigned DataWidth    = 512,
    parameter int unsigned CounterWidth = 8,
    parameter int unsigned CountWidth   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DataWidth-1:0]  in_data_i,
    input  logic                  finalize_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DataWidth-1:0]  out_data_o,
    output logic [CountWidth-1:0] num_bundled_o
);

    typedef logic signed [CounterWidth-1:0] cnt_t;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_e;

    localparam cnt_t CntMax = cnt_t'({1'b0, {(CounterWidth-1){1'b1}}});
    localparam cnt_t CntMin = cnt_t'({1'b1, {(CounterWidth-1){1'b0}}});
    localparam cnt_t CntOne = cnt_t'(1);

    state_e                state_q, state_d;
    cnt_t                  cnt_q [DataWidth];
    cnt_t                  cnt_d [DataWidth];
    logic [CountWidth-1:0] num_q, num_d;
    logic                  accept;

    // One vote on a counter; the build decides whether the extremes clamp or wrap.
    function automatic cnt_t cnt_step(input cnt_t c, input logic up);
`ifdef HV_BUNDLER_SATURATE_EN
        if (up) begin
            return (c == CntMax) ? c : cnt_t'(c + CntOne);
        end
        return (c == CntMin) ? c : cnt_t'(c - CntOne);
`else
        return up ? cnt_t'(c + CntOne) : cnt_t'(c - CntOne);
`endif
    endfunction

    function automatic logic [CountWidth-1:0] num_step(input logic [CountWidth-1:0] n);
        return (n == {CountWidth{1'b1}}) ? n : n + CountWidth'(1);
    endfunction

    assign in_ready_o    = (state_q == ACCUM);
    assign out_valid_o   = (state_q == DRAIN);
    assign accept        = in_valid_i && in_ready_o;
    assign num_bundled_o = num_q;

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        for (int unsigned i = 0; i < DataWidth; i++) begin
            cnt_d[i] = cnt_q[i];
        end

        if (clr_i) begin
            state_d = ACCUM;
            num_d   = '0;
            for (int unsigned i = 0; i < DataWidth; i++) begin
                cnt_d[i] = '0;
            end
        end else begin
            unique case (state_q)
                ACCUM: begin
                    // A vector arriving with finalize still lands in this bundle.
                    if (accept) begin
                        num_d = num_step(num_q);
                        for (int unsigned i = 0; i < DataWidth; i++) begin
                            cnt_d[i] = cnt_step(cnt_q[i], in_data_i[i]);
                        end
                    end
                    if (finalize_i) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_ready_i) begin
                        state_d = ACCUM;
                        num_d   = '0;
                        for (int unsigned i = 0; i < DataWidth; i++) begin
                            cnt_d[i] = '0;
                        end
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ACCUM;
            num_q   <= '0;
            for (int unsigned i = 0; i < DataWidth; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            for (int unsigned i = 0; i < DataWidth; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Strictly positive wins, so a tie binarizes to 0; gated low outside DRAIN.
    always_comb begin
        out_data_o = '0;
        if (state_q == DRAIN) begin
            for (int unsigned i = 0; i < DataWidth; i++) begin
                out_data_o[i] = (cnt_q[i] > cnt_t'(0));
            end
        end
    end

endmodule

// File: tb/tb_hv_bundler_unit.sv
// Directed bench for hv_bundler_unit at DataWidth=8 with hand-computed expectations.
module tb_hv_bundler_unit;

    localparam int DW = 8;
    localparam int NW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          finalize;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [NW-1:0] num_bundled;

    int checks = 0;
    int errors = 0;

    hv_bundler_unit #(
        .DataWidth   (DW),
        .CounterWidth(8),
        .CountWidth  (NW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clr_i        (clr),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (in_data),
        .finalize_i   (finalize),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .num_bundled_o(num_bundled)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        in_data   = '0;
        finalize  = 1'b0;
        out_ready = 1'b0;
        clr       = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic fin();
        finalize = 1'b1;
        tick();
        finalize = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    logic [DW-1:0] ovf_exp;

    initial begin
        idle();
        rst_n = 1'b0;
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_num", 32'(num_bundled), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Majority of three
        push(8'hF0);
        push(8'hCC);
        check("num_after_2", 32'(num_bundled), 32'd2);
        check("accum_out_data_zero", 32'(out_data), 32'h0);
        push(8'hAA);
        fin();
        check("maj_out_valid", 32'(out_valid), 32'd1);
        check("maj_in_ready", 32'(in_ready), 32'd0);
        check("maj_out_data", 32'(out_data), 32'hE8);
        check("maj_num", 32'(num_bundled), 32'd3);
        drain();
        check("maj_post_in_ready", 32'(in_ready), 32'd1);
        check("maj_post_out_valid", 32'(out_valid), 32'd0);
        check("maj_post_num", 32'(num_bundled), 32'd0);
        check("maj_post_out_data", 32'(out_data), 32'h0);

        // Tie
        push(8'hFF);
        push(8'h00);
        fin();
        check("tie_out_valid", 32'(out_valid), 32'd1);
        check("tie_out_data", 32'(out_data), 32'h00);
        check("tie_num", 32'(num_bundled), 32'd2);
        drain();

        // Empty finalize
        fin();
        check("empty_out_valid", 32'(out_valid), 32'd1);
        check("empty_out_data", 32'(out_data), 32'h00);
        check("empty_num", 32'(num_bundled), 32'd0);
        drain();

        // Same-cycle input and finalize, then backpressure with ignored input/finalize
        in_valid = 1'b1;
        in_data  = 8'h01;
        finalize = 1'b1;
        tick();
        check("same_out_valid", 32'(out_valid), 32'd1);
        check("same_out_data", 32'(out_data), 32'h01);
        check("same_num", 32'(num_bundled), 32'd1);
        in_data = 8'hFF;
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("bp_out_data_%0d", c), 32'(out_data), 32'h01);
            check($sformatf("bp_in_ready_%0d", c), 32'(in_ready), 32'd0);
            check($sformatf("bp_out_valid_%0d", c), 32'(out_valid), 32'd1);
            check($sformatf("bp_num_%0d", c), 32'(num_bundled), 32'd1);
        end
        idle();
        drain();
        check("bp_post_num", 32'(num_bundled), 32'd0);
        fin();
        check("bp_cleared_out_data", 32'(out_data), 32'h00);
        drain();

        // Overflow: 130 votes for bit 0, 130 against bits 7..1
        in_valid = 1'b1;
        in_data  = 8'h01;
        for (int c = 0; c < 130; c++) begin
            tick();
        end
        in_valid = 1'b0;
        check("ovf_num_accum", 32'(num_bundled), 32'd130);
        fin();
`ifdef HV_BUNDLER_SATURATE_EN
        ovf_exp = 8'h01;
`else
        ovf_exp = 8'hFE;
`endif
        check("ovf_out_data", 32'(out_data), 32'(ovf_exp));
        check("ovf_num", 32'(num_bundled), 32'd130);
        drain();

        // Clear mid-DRAIN
        push(8'h0F);
        fin();
        check("clr_pre_valid", 32'(out_valid), 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_out_valid", 32'(out_valid), 32'd0);
        check("clr_num", 32'(num_bundled), 32'd0);
        check("clr_in_ready", 32'(in_ready), 32'd1);

        // Clear drops concurrent input and finalize
        push(8'hFF);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        finalize = 1'b1;
        tick();
        idle();
        check("clr_drop_valid", 32'(out_valid), 32'd0);
        check("clr_drop_num", 32'(num_bundled), 32'd0);
        fin();
        check("clr_drop_out_data", 32'(out_data), 32'h00);
        drain();

        // Asynchronous reset mid-ACCUM
        push(8'hFF);
        push(8'hFF);
        check("prerst_num", 32'(num_bundled), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_num", 32'(num_bundled), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        fin();
        check("arst_out_data", 32'(out_data), 32'h00);
        drain();

        // Asynchronous reset mid-DRAIN
        push(8'hFF);
        fin();
        check("drain_rst_pre_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("drain_rst_out_valid", 32'(out_valid), 32'd0);
        check("drain_rst_out_data", 32'(out_data), 32'h00);
        tick();
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
